// File: rtl/spi_regfile.sv
// Register file behind an SPI slave: synchronizes the slave's latch levels, decodes read/write frames.
// Optional SPI_REGFILE_TXCNT_EN turns index 15 into a read-only transaction counter.
module spi_regfile #(
  parameter int                    ADRSIZE  = 8,
  parameter int                    DATASIZE = 32,
  parameter logic [DATASIZE-1:0]   ID_WORD  = 32'hC0FFEE01
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     adr_latched,
  input  logic                     data_latched,
  input  logic [ADRSIZE-1:0]       adr,
  input  logic [DATASIZE-1:0]      data_wr,
  output logic [DATASIZE-1:0]      data_rd,
  output logic [16*DATASIZE-1:0]   regs_flat,
  output logic [15:0]              wr_strobe,
  output logic                     err_ro
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADR = 2'd1, DATA = 2'd2} state_t;

`ifdef SPI_REGFILE_TXCNT_EN
  localparam logic [15:0] RO_MASK = 16'hC001;
`else
  localparam logic [15:0] RO_MASK = 16'h4001;
`endif

  state_t               state_reg, state_next;
  logic [2:0]           adr_sync_reg, data_sync_reg;  // [0] sync1, [1] sync2, [2] history
  logic [ADRSIZE-1:0]   adr_q_reg;
  logic [15:0]          strobe_next, wr_strobe_reg;
  logic                 err_ro_reg;
  logic [DATASIZE-1:0]  data_rd_reg;
  logic [DATASIZE-1:0]  reg_view [16];
  logic                 adr_rise, data_rise, capture, set_err, clr_err;
  logic [3:0]           idx;

  assign adr_rise  = adr_sync_reg[1]  & ~adr_sync_reg[2];
  assign data_rise = data_sync_reg[1] & ~data_sync_reg[2];
  assign idx       = adr_q_reg[3:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      adr_sync_reg  <= '0;
      data_sync_reg <= '0;
      adr_q_reg     <= '0;
      wr_strobe_reg <= '0;
      err_ro_reg    <= 1'b0;
      data_rd_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      adr_sync_reg  <= {adr_sync_reg[1:0], adr_latched};
      data_sync_reg <= {data_sync_reg[1:0], data_latched};
      wr_strobe_reg <= strobe_next;
      data_rd_reg   <= reg_view[adr[3:0]];
      if (capture)
        adr_q_reg <= adr;
      if (set_err)
        err_ro_reg <= 1'b1;
      else if (clr_err)
        err_ro_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    strobe_next = '0;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    case (state_reg)
      IDLE: if (adr_rise) begin
        capture    = 1'b1;
        state_next = ADR;
      end
      ADR: begin
        if (data_rise)
          state_next = DATA;
        else if (!adr_sync_reg[1])
          state_next = IDLE;   // frame aborted before the data word arrived
      end
      DATA: begin
        state_next = IDLE;
        if (adr_q_reg[ADRSIZE-1]) begin
          if (RO_MASK[idx]) begin
            set_err = 1'b1;
          end else begin
            strobe_next[idx] = 1'b1;
            clr_err          = (idx == 4'd15) && data_wr[0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SPI_REGFILE_TXCNT_EN
  logic [DATASIZE-1:0] txcnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      txcnt_reg <= '0;
    else if (state_reg == ADR && state_next == DATA)
      txcnt_reg <= txcnt_reg + 1'b1;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign reg_view[gi] = ID_WORD;
      end else if (gi == 14) begin : g_status
        assign reg_view[gi] = DATASIZE'({err_ro_reg, state_reg, 1'b0});
`ifdef SPI_REGFILE_TXCNT_EN
      end else if (gi == 15) begin : g_txcnt
        assign reg_view[gi] = txcnt_reg;
`endif
      end else begin : g_rw
        logic [DATASIZE-1:0] q_reg;
        always_ff @(posedge clock or posedge reset) begin
          if (reset)
            q_reg <= '0;
          else if (strobe_next[gi])
            q_reg <= data_wr;
        end
        assign reg_view[gi] = q_reg;
      end
      assign regs_flat[gi*DATASIZE +: DATASIZE] = reg_view[gi];
    end
  endgenerate

  assign data_rd   = data_rd_reg;
  assign wr_strobe = wr_strobe_reg;
  assign err_ro    = err_ro_reg;

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; parameters and ports SHALL be as listed below.
- ADRSIZE, 8, SPI address width; adr[7] is the write flag (1 write, 0 read) and adr[3:0] is the register index.
- DATASIZE, 32, register width.
- ID_WORD, 32'hC0FFEE01, read-only contents of register 0.
- clock  in  1  system clock, at least 8x the SPI sclk frequency.
- reset  in  1  asynchronous, active-high.
- adr_latched  in  1  level from the SPI slave (sclk domain); rises once the address is captured and clears at the next frame start.
- data_latched  in  1  level from the SPI slave (sclk domain); rises once the data word is captured.
- adr  in  ADRSIZE  address from the SPI slave; stable while adr_latched is high.
- data_wr  in  DATASIZE  write word from the SPI slave; stable while data_latched is high.
- data_rd  out  DATASIZE  readback word to the SPI slave.
- regs_flat  out  16*DATASIZE  all registers; register n occupies bits [n*32+31 : n*32].
- wr_strobe  out  16  one-hot, one-cycle pulse marking the register written.
- err_ro  out  1  sticky flag: a write targeted a read-only register.

Function
REQ-002 adr_latched and data_latched SHALL each pass through a 2-flop synchronizer plus a third history flop; a rise is detected when sync2 is 1 and history is 0.
REQ-003 The FSM SHALL have three states: IDLE, ADR, DATA.
REQ-004 In IDLE, an adr_latched rise SHALL capture adr into adr_q and move to ADR.
REQ-005 In ADR, a data_latched rise SHALL move to DATA; sync2(adr_latched) reading 0 (aborted frame) SHALL return to IDLE with no write.
REQ-006 In DATA, when adr_q[7]=1 and the index is writable, the FSM SHALL write data_wr into the register, pulse the matching wr_strobe bit, and return to IDLE, all in one cycle.
REQ-007 Register writes SHALL land on the 4th rising clock edge after data_latched is first sampled high.
REQ-008 Indices 0 (ID_WORD) and 14 (status) SHALL be read-only; a write to either SHALL be dropped, set err_ro, and pulse no wr_strobe bit.
REQ-009 Register 14 SHALL read {28'b0, err_ro, state[1:0], 1'b0}.
REQ-010 A read (adr_q[7]=0) SHALL reach DATA and return to IDLE with no state change and no strobe.
REQ-011 data_rd SHALL be registered each cycle from the register indexed by adr[3:0] (raw input, quasi-static), giving 1-cycle latency.
- This timing is required so data_rd settles before the SPI slave's first miso falling edge.
REQ-012 err_ro SHALL clear only on reset, or on a write of bit0=1 to index 15 while 15 is a plain register.
REQ-013 An adr_latched rise seen in any state other than IDLE SHALL be ignored until the FSM reaches IDLE.

Reset
REQ-014 On reset the block SHALL drive the following values asynchronously: FSM=IDLE; all sync and history flops=0; adr_q=0; registers 1-15=0; wr_strobe=0; err_ro=0; data_rd=0.
REQ-015 A reset asserted mid-transaction SHALL discard any pending write; after release, the next write SHALL require a fresh adr_latched rise.

Configuration
REQ-016 With SPI_REGFILE_TXCNT_EN defined, index 15 SHALL be a read-only 32-bit counter, incremented on every DATA state entry and wrapping from FFFFFFFF to 0.
- Writes to index 15 then set err_ro, and the err_ro clear-by-write of REQ-012 is unavailable.
REQ-017 Without SPI_REGFILE_TXCNT_EN, index 15 SHALL be a plain read/write register.

Verification
REQ-018 Write adr=8'h83, data=32'h12345678 -> regs[3]=12345678, wr_strobe=16'h0008 for exactly one cycle, err_ro=0.
REQ-019 Write adr=8'h80, data=32'hFFFFFFFF -> regs[0] stays C0FFEE01, err_ro=1, wr_strobe stays 0.
REQ-020 Read adr=8'h03 after REQ-018 -> data_rd=12345678 one clock after adr is applied; no strobe pulse.
REQ-021 Raise adr_latched for adr=8'h85, then drop it before data_latched -> FSM back to IDLE, regs[5] unchanged.
REQ-022 Assert reset between the adr_latched and data_latched rises of adr=8'h82 -> regs[2]=0; a following complete write adr=8'h82, data=32'hA5A5A5A5 succeeds.
REQ-023 With SPI_REGFILE_TXCNT_EN, preload the counter to FFFFFFFF and run one transaction -> regs[15]=0.
